// File: rtl/idli_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : idli_pkg
//  Description : Shared types and helpers for the idli core control block.
//  Revision    : 1.0 - initial release
// ============================================================================
package idli_pkg;

    typedef enum logic [1:0] {
        CTL_BOOT  = 2'd0,
        CTL_RUN   = 2'd1,
        CTL_STALL = 2'd2,
        CTL_FLUSH = 2'd3
    } ctl_state_t;

    // Counter width able to index n distinct values, never below one bit.
    function automatic int unsigned ctl_cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned c_data_w_dflt  = 16;
    localparam int unsigned c_slice_w_dflt = 4;
    localparam int unsigned c_ctr_w_dflt   = ctl_cnt_w(c_data_w_dflt / c_slice_w_dflt);

    typedef logic [c_ctr_w_dflt-1:0] ctr_t;

endpackage
`default_nettype wire

// File: rtl/idli_ctrl_timer_m.sv
`default_nettype none
// ============================================================================
//  Module      : idli_ctrl_timer_m
//  Description : Count-to-N timer; o_last flags the final count of a period.
//  Revision    : 1.0 - initial release
// ============================================================================
module idli_ctrl_timer_m
    import idli_pkg::*;
#(
    parameter int unsigned COUNT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_last
);

    localparam int unsigned          c_cnt_w = ctl_cnt_w(COUNT);
    localparam logic [c_cnt_w-1:0]   c_last  = c_cnt_w'(COUNT - 1);

    logic [c_cnt_w-1:0] cnt_q;
    logic [c_cnt_w-1:0] cnt_d;

    // The count wraps on its last value so back-to-back periods need no clear.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_en) begin
            cnt_d = (cnt_q == c_last) ? '0 : cnt_q + c_cnt_w'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_last = (cnt_q == c_last);

endmodule
`default_nettype wire

// File: rtl/idli_ctrl_m.sv
`default_nettype none
// ============================================================================
//  Module      : idli_ctrl_m
//  Description : Core sync/control: slice counter, boot hold-off, word-aligned
//                stall, redirect capture with pipeline flush, issue gating.
//  Revision    : 1.0 - initial release
// ============================================================================
module idli_ctrl_m
    import idli_pkg::*;
#(
    parameter  int unsigned DATA_W      = 16,
    parameter  int unsigned SLICE_W     = 4,
    parameter  int unsigned BOOT_CYCLES = 8,
    parameter  int unsigned FLUSH_WORDS = 1,
    localparam int unsigned NUM_SLICES  = DATA_W / SLICE_W,
    localparam int unsigned CTR_W       = ctl_cnt_w(NUM_SLICES)
) (
    input  logic              i_ctl_gck,
    input  logic              i_ctl_rst,
    input  logic              i_ctl_stall,
    input  logic              i_ctl_redirect,
    input  logic [DATA_W-1:0] i_ctl_redirect_pc,
    input  logic              i_ctl_instr_vld,
    output logic [CTR_W-1:0]  o_ctl_ctr,
    output logic              o_ctl_word_start,
    output logic              o_ctl_word_end,
    output logic              o_ctl_run,
    output logic              o_ctl_flush,
    output logic              o_ctl_redirect,
    output logic [DATA_W-1:0] o_ctl_redirect_pc,
    output logic              o_ctl_issue
);

    localparam logic [CTR_W-1:0] c_ctr_last = CTR_W'(NUM_SLICES - 1);

    ctl_state_t        state_q,   state_d;
    logic [CTR_W-1:0]  ctr_q,     ctr_d;
    logic              pending_q, pending_d;
    logic              pulse_q,   pulse_d;
    logic [DATA_W-1:0] pc_q,      pc_d;

    logic w_active;
    logic w_counting;
    logic w_ctr_last;
    logic w_redir_now;
    logic w_boot_done;
    logic w_flush_last;
    logic w_enter_flush;

    assign w_active    = (state_q != CTL_BOOT);
    assign w_counting  = (state_q == CTL_RUN) || (state_q == CTL_FLUSH);
    assign w_ctr_last  = (ctr_q == c_ctr_last);
    // A redirect arriving on the deciding edge counts as already pending.
    assign w_redir_now = pending_q || (i_ctl_redirect && w_active);

    idli_ctrl_timer_m #(.COUNT(BOOT_CYCLES)) u_boot_timer (
        .clk    (i_ctl_gck),
        .rst    (i_ctl_rst),
        .i_clr  (state_q != CTL_BOOT),
        .i_en   (state_q == CTL_BOOT),
        .o_last (w_boot_done)
    );

    idli_ctrl_timer_m #(.COUNT(FLUSH_WORDS)) u_flush_timer (
        .clk    (i_ctl_gck),
        .rst    (i_ctl_rst),
        .i_clr  (state_q != CTL_FLUSH),
        .i_en   ((state_q == CTL_FLUSH) && w_ctr_last),
        .o_last (w_flush_last)
    );

    always_comb begin
        state_d       = state_q;
        ctr_d         = '0;
        pending_d     = pending_q;
        pulse_d       = 1'b0;
        pc_d          = pc_q;
        w_enter_flush = 1'b0;

        if (i_ctl_redirect && w_active) begin
            pending_d = 1'b1;
            pc_d      = i_ctl_redirect_pc;
        end

        case (state_q)
            CTL_BOOT: begin
                if (w_boot_done) state_d = CTL_RUN;
            end
            CTL_RUN: begin
                ctr_d = w_ctr_last ? '0 : ctr_q + CTR_W'(1);
                if (w_ctr_last) begin
                    if (w_redir_now)      w_enter_flush = 1'b1;
                    else if (i_ctl_stall) state_d = CTL_STALL;
                end
            end
            CTL_STALL: begin
                if (w_redir_now)       w_enter_flush = 1'b1;
                else if (!i_ctl_stall) state_d = CTL_RUN;
            end
            CTL_FLUSH: begin
                ctr_d = w_ctr_last ? '0 : ctr_q + CTR_W'(1);
                if (w_ctr_last && w_flush_last) begin
                    if (w_redir_now)      w_enter_flush = 1'b1;
                    else if (i_ctl_stall) state_d = CTL_STALL;
                    else                  state_d = CTL_RUN;
                end
            end
            default: state_d = CTL_BOOT;
        endcase

        if (w_enter_flush) begin
            state_d   = CTL_FLUSH;
            pending_d = 1'b0;
            pulse_d   = 1'b1;
        end
    end

    always_ff @(posedge i_ctl_gck) begin
        if (i_ctl_rst) begin
            state_q   <= CTL_BOOT;
            ctr_q     <= '0;
            pending_q <= 1'b0;
            pulse_q   <= 1'b0;
            pc_q      <= '0;
        end else begin
            state_q   <= state_d;
            ctr_q     <= ctr_d;
            pending_q <= pending_d;
            pulse_q   <= pulse_d;
            pc_q      <= pc_d;
        end
    end

    assign o_ctl_ctr         = ctr_q;
    assign o_ctl_word_start  = w_counting && (ctr_q == '0);
    assign o_ctl_word_end    = w_counting && w_ctr_last;
    assign o_ctl_run         = (state_q == CTL_RUN);
    assign o_ctl_flush       = (state_q == CTL_FLUSH);
    assign o_ctl_redirect    = pulse_q;
    assign o_ctl_redirect_pc = pulse_q ? pc_q : '0;
    assign o_ctl_issue       = i_ctl_instr_vld && o_ctl_run && o_ctl_word_start;

endmodule
`default_nettype wire

// File: tb/tb_idli_ctrl_m.sv
`default_nettype none
// ============================================================================
//  Module      : tb_idli_ctrl_m
//  Description : Scoreboard bench for idli_ctrl_m, default and 32-bit configs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_idli_ctrl_m;

    typedef struct {
        int          id;
        bit          sel;
        int          ctr;
        logic        ws, we, run, fl, rd, iss;
        logic [31:0] pc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: default 16/4, boot 8, flush 1
    logic        rst_a = 1'b1, stall_a = 1'b0, rd_a = 1'b0, vld_a = 1'b1;
    logic [15:0] pc_in_a = '0;
    logic [1:0]  ctr_a;
    logic        ws_a, we_a, run_a, fl_a, rdo_a, iss_a;
    logic [15:0] pc_a;

    // Instance B: 32/4, boot 3, flush 2
    logic        rst_b = 1'b1, stall_b = 1'b0, rd_b = 1'b0, vld_b = 1'b1;
    logic [31:0] pc_in_b = '0;
    logic [2:0]  ctr_b;
    logic        ws_b, we_b, run_b, fl_b, rdo_b, iss_b;
    logic [31:0] pc_b;

    idli_ctrl_m u_dut_a (
        .i_ctl_gck(clk), .i_ctl_rst(rst_a), .i_ctl_stall(stall_a),
        .i_ctl_redirect(rd_a), .i_ctl_redirect_pc(pc_in_a), .i_ctl_instr_vld(vld_a),
        .o_ctl_ctr(ctr_a), .o_ctl_word_start(ws_a), .o_ctl_word_end(we_a),
        .o_ctl_run(run_a), .o_ctl_flush(fl_a), .o_ctl_redirect(rdo_a),
        .o_ctl_redirect_pc(pc_a), .o_ctl_issue(iss_a)
    );

    idli_ctrl_m #(.DATA_W(32), .SLICE_W(4), .BOOT_CYCLES(3), .FLUSH_WORDS(2)) u_dut_b (
        .i_ctl_gck(clk), .i_ctl_rst(rst_b), .i_ctl_stall(stall_b),
        .i_ctl_redirect(rd_b), .i_ctl_redirect_pc(pc_in_b), .i_ctl_instr_vld(vld_b),
        .o_ctl_ctr(ctr_b), .o_ctl_word_start(ws_b), .o_ctl_word_end(we_b),
        .o_ctl_run(run_b), .o_ctl_flush(fl_b), .o_ctl_redirect(rdo_b),
        .o_ctl_redirect_pc(pc_b), .o_ctl_issue(iss_b)
    );

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_step  = 0;

    function automatic exp_t ez();
        exp_t e;
        e.id = 0; e.sel = 1'b0; e.ctr = 0;
        e.ws = 1'b0; e.we = 1'b0; e.run = 1'b0; e.fl = 1'b0; e.rd = 1'b0; e.iss = 1'b0;
        e.pc = '0;
        return e;
    endfunction

    function automatic exp_t es();
        return ez();
    endfunction

    function automatic exp_t er(input int ctr, input int num, input bit vld);
        exp_t e = ez();
        e.ctr = ctr; e.run = 1'b1;
        e.ws = (ctr == 0); e.we = (ctr == num - 1);
        e.iss = vld && (ctr == 0);
        return e;
    endfunction

    function automatic exp_t ef(input int ctr, input int num, input bit rd, input logic [31:0] pc);
        exp_t e = ez();
        e.ctr = ctr; e.fl = 1'b1;
        e.ws = (ctr == 0); e.we = (ctr == num - 1);
        e.rd = rd; e.pc = pc;
        return e;
    endfunction

    // Apply inputs just after the edge and queue what this cycle must show.
    task automatic step(input bit sel, input bit rst, input bit stall, input bit rd,
                        input logic [31:0] pc, input bit vld, input exp_t e);
        @(posedge clk);
        #1;
        if (!sel) begin
            rst_a = rst; stall_a = stall; rd_a = rd; pc_in_a = pc[15:0]; vld_a = vld;
        end else begin
            rst_b = rst; stall_b = stall; rd_b = rd; pc_in_b = pc; vld_b = vld;
        end
        n_step++;
        e.id  = n_step;
        e.sel = sel;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            exp_t a;
            e = exp_q.pop_front();
            a = ez();
            if (!e.sel) begin
                a.ctr = int'(ctr_a); a.ws = ws_a; a.we = we_a; a.run = run_a; a.fl = fl_a;
                a.rd = rdo_a; a.pc = {16'h0, pc_a}; a.iss = iss_a;
            end else begin
                a.ctr = int'(ctr_b); a.ws = ws_b; a.we = we_b; a.run = run_b; a.fl = fl_b;
                a.rd = rdo_b; a.pc = pc_b; a.iss = iss_b;
            end
            n_tests++;
            if (a.ctr !== e.ctr || a.ws !== e.ws || a.we !== e.we || a.run !== e.run ||
                a.fl !== e.fl || a.rd !== e.rd || a.pc !== e.pc || a.iss !== e.iss) begin
                n_fail++;
                $display("FAIL step%0d dut%s: got ctr=%0d ws=%b we=%b run=%b flush=%b redir=%b pc=%h issue=%b, want ctr=%0d ws=%b we=%b run=%b flush=%b redir=%b pc=%h issue=%b",
                         e.id, e.sel ? "B" : "A",
                         a.ctr, a.ws, a.we, a.run, a.fl, a.rd, a.pc, a.iss,
                         e.ctr, e.ws, e.we, e.run, e.fl, e.rd, e.pc, e.iss);
            end
        end
    end

    initial begin
        // ---------------- instance A ----------------
        step(0, 1, 0, 0, 0, 1, ez());
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, 1, ez());
        for (int c = 0; c < 4; c++) step(0, 0, 0, 0, 0, 1, er(c, 4, 1));
        step(0, 0, 0, 0, 0, 1, er(0, 4, 1));
        // stall raised mid-word, only acted on at the word end
        step(0, 0, 1, 0, 0, 1, er(1, 4, 1));
        step(0, 0, 1, 0, 0, 1, er(2, 4, 1));
        step(0, 0, 1, 0, 0, 1, er(3, 4, 1));
        step(0, 0, 1, 0, 0, 1, es());
        step(0, 0, 0, 0, 0, 1, es());
        step(0, 0, 0, 0, 0, 1, er(0, 4, 1));
        // single redirect at ctr 1
        step(0, 0, 0, 1, 32'h1234, 1, er(1, 4, 1));
        step(0, 0, 0, 0, 0, 1, er(2, 4, 1));
        step(0, 0, 0, 0, 0, 1, er(3, 4, 1));
        step(0, 0, 0, 0, 0, 1, ef(0, 4, 1, 32'h1234));
        for (int c = 1; c < 4; c++) step(0, 0, 0, 0, 0, 1, ef(c, 4, 0, 0));
        // two redirects in one word, latest wins; instr_vld low blocks issue
        step(0, 0, 0, 1, 32'h0010, 0, er(0, 4, 0));
        step(0, 0, 0, 0, 0, 1, er(1, 4, 1));
        step(0, 0, 0, 1, 32'h0020, 1, er(2, 4, 1));
        step(0, 0, 0, 0, 0, 1, er(3, 4, 1));
        step(0, 0, 0, 0, 0, 1, ef(0, 4, 1, 32'h0020));
        for (int c = 1; c < 4; c++) step(0, 0, 0, 0, 0, 1, ef(c, 4, 0, 0));
        // stall and redirect together at word end
        step(0, 0, 0, 0, 0, 1, er(0, 4, 1));
        step(0, 0, 0, 0, 0, 1, er(1, 4, 1));
        step(0, 0, 0, 0, 0, 1, er(2, 4, 1));
        step(0, 0, 1, 1, 32'hBEEF, 1, er(3, 4, 1));
        step(0, 0, 1, 0, 0, 1, ef(0, 4, 1, 32'hBEEF));
        for (int c = 1; c < 4; c++) step(0, 0, 1, 0, 0, 1, ef(c, 4, 0, 0));
        step(0, 0, 0, 0, 0, 1, es());
        step(0, 0, 0, 0, 0, 1, er(0, 4, 1));
        // redirect during FLUSH chains a second FLUSH
        step(0, 0, 0, 0, 0, 1, er(1, 4, 1));
        step(0, 0, 0, 1, 32'h00AA, 1, er(2, 4, 1));
        step(0, 0, 0, 0, 0, 1, er(3, 4, 1));
        step(0, 0, 0, 0, 0, 1, ef(0, 4, 1, 32'h00AA));
        step(0, 0, 0, 1, 32'h0055, 1, ef(1, 4, 0, 0));
        step(0, 0, 0, 0, 0, 1, ef(2, 4, 0, 0));
        step(0, 0, 0, 0, 0, 1, ef(3, 4, 0, 0));
        step(0, 0, 0, 0, 0, 1, ef(0, 4, 1, 32'h0055));
        for (int c = 1; c < 4; c++) step(0, 0, 0, 0, 0, 1, ef(c, 4, 0, 0));
        step(0, 0, 0, 0, 0, 1, er(0, 4, 1));

        // ---------------- instance B ----------------
        step(1, 1, 0, 0, 0, 1, ez());
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 1, ez());
        for (int c = 0; c < 7; c++) step(1, 0, 0, 0, 0, 1, er(c, 8, 1));
        step(1, 0, 0, 1, 32'hCAFEF00D, 1, er(7, 8, 1));
        step(1, 0, 0, 0, 0, 1, ef(0, 8, 1, 32'hCAFEF00D));
        for (int c = 1; c < 8; c++) step(1, 0, 0, 0, 0, 1, ef(c, 8, 0, 0));
        // second flush word: no pulse; redirect then reset discards it
        step(1, 0, 0, 1, 32'h00001111, 1, ef(0, 8, 0, 0));
        step(1, 1, 0, 0, 0, 1, ef(1, 8, 0, 0));
        step(1, 1, 0, 0, 0, 1, ez());
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 1, ez());
        for (int c = 0; c < 8; c++) step(1, 0, 0, 0, 0, 1, er(c, 8, 1));
        step(1, 0, 0, 0, 0, 1, er(0, 8, 1));

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
